// File: rtl/button_toggle_if.sv
// Button-side signal bundle: raw pushbutton in, clean enable/level/press out.
// The master drives the button; the slave (the debouncer) drives the outputs.
interface button_toggle_if;
   logic btn_in;
   logic on;
   logic btn_level;
   logic press;

   modport master (output btn_in, input on, input btn_level, input press);
   modport slave  (input btn_in, output on, output btn_level, output press);
endinterface

// File: rtl/button_toggle.sv
// Pushbutton conditioner: 2-flop synchroniser, counter debounce FSM, and a
// toggled `on` enable plus debounced level and one-cycle press pulse.
//
// state        | meaning
// -------------+------------------------------------------------------------
// RELEASED     | debounced level is released, waiting for a pressed sample
// PRESS_WAIT   | counting consecutive pressed samples towards DEBOUNCE_CYCLES
// PRESSED      | debounced level is pressed, waiting for a released sample
// RELEASE_WAIT | counting consecutive released samples towards DEBOUNCE_CYCLES
module button_toggle #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter bit          BTN_ACTIVE_LOW  = 1'b0,
   parameter bit          ON_RESET        = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   button_toggle_if.slave  bt
);

   localparam int unsigned    CW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   // With a single required cycle the wait states collapse into the entry edge.
   localparam bit             SINGLE  = (DEBOUNCE_CYCLES == 1);

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   logic          cnt_hit;
   logic          sync_q1;
   logic          sync_q2;
   logic          btn_pressed;
   logic          on_q;
   logic          level_q;
   logic          press_q;

   // Synchroniser flops reset to the released level so reset never looks like a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= BTN_ACTIVE_LOW;
         sync_q2 <= BTN_ACTIVE_LOW;
      end else begin
         sync_q1 <= bt.btn_in;
         sync_q2 <= sync_q1;
      end
   end

   assign btn_pressed = sync_q2 ^ BTN_ACTIVE_LOW;
   assign cnt_inc     = cnt + CNT_ONE;
   assign cnt_hit     = (cnt_inc == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RELEASED;
         cnt     <= '0;
         on_q    <= ON_RESET;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         press_q <= 1'b0;
         case (state)
            RELEASED: begin
               if (btn_pressed) begin
                  if (SINGLE) begin
                     state   <= PRESSED;
                     cnt     <= '0;
                     level_q <= 1'b1;
                     press_q <= 1'b1;
                     on_q    <= ~on_q;
                  end else begin
                     state <= PRESS_WAIT;
                     cnt   <= CNT_ONE;
                  end
               end
            end
            PRESS_WAIT: begin
               if (!btn_pressed) begin
                  state <= RELEASED;
                  cnt   <= '0;
               end else if (cnt_hit) begin
                  state   <= PRESSED;
                  cnt     <= '0;
                  level_q <= 1'b1;
                  press_q <= 1'b1;
                  on_q    <= ~on_q;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            PRESSED: begin
               if (!btn_pressed) begin
                  if (SINGLE) begin
                     state   <= RELEASED;
                     cnt     <= '0;
                     level_q <= 1'b0;
                  end else begin
                     state <= RELEASE_WAIT;
                     cnt   <= CNT_ONE;
                  end
               end
            end
            RELEASE_WAIT: begin
               if (btn_pressed) begin
                  state <= PRESSED;
                  cnt   <= '0;
               end else if (cnt_hit) begin
                  state   <= RELEASED;
                  cnt     <= '0;
                  level_q <= 1'b0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               state <= RELEASED;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign bt.on        = on_q;
   assign bt.btn_level = level_q;
   assign bt.press     = press_q;

endmodule

// File: tb/tb_button_toggle.sv
// Scoreboard bench: stimulus queues expected output changes (edge index + value),
// a negedge monitor pops and compares every observed change of {on, btn_level, press}.
module tb_button_toggle;

   typedef struct packed {
      int         t;
      logic [2:0] v;   // {on, btn_level, press}
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   pass_cnt;
   int   total_cnt;
   exp_t q4[$];
   exp_t q1[$];
   logic [2:0] prev4;
   logic [2:0] prev1;
   logic [2:0] cur4;
   logic [2:0] cur1;

   button_toggle_if if4 ();
   button_toggle_if if1 ();

   button_toggle #(.DEBOUNCE_CYCLES(4), .BTN_ACTIVE_LOW(1'b0), .ON_RESET(1'b0)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bt    (if4)
   );

   button_toggle #(.DEBOUNCE_CYCLES(1), .BTN_ACTIVE_LOW(1'b0), .ON_RESET(1'b0)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bt    (if1)
   );

   assign cur4 = {if4.on, if4.btn_level, if4.press};
   assign cur1 = {if1.on, if1.btn_level, if1.press};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   // Monitor: every change of the output triple must match the head of its queue.
   initial begin
      prev4 = 3'b000;
      prev1 = 3'b000;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         prev4 = cur4;
         prev1 = cur1;
      end else begin
         if (cur4 != prev4) begin
            total_cnt = total_cnt + 1;
            if (q4.size() == 0) begin
               $display("FAIL d4_event unexpected at edge %0d: got %b, expected no change", cyc, cur4);
            end else begin
               exp_t e;
               e = q4.pop_front();
               if (e.t == cyc && e.v == cur4) pass_cnt = pass_cnt + 1;
               else $display("FAIL d4_event: got %b at edge %0d, expected %b at edge %0d", cur4, cyc, e.v, e.t);
            end
         end
         if (cur1 != prev1) begin
            total_cnt = total_cnt + 1;
            if (q1.size() == 0) begin
               $display("FAIL d1_event unexpected at edge %0d: got %b, expected no change", cyc, cur1);
            end else begin
               exp_t e;
               e = q1.pop_front();
               if (e.t == cyc && e.v == cur1) pass_cnt = pass_cnt + 1;
               else $display("FAIL d1_event: got %b at edge %0d, expected %b at edge %0d", cur1, cyc, e.v, e.t);
            end
         end
         prev4 = cur4;
         prev1 = cur1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic check(input string name, input logic [2:0] got, input logic [2:0] want);
      total_cnt = total_cnt + 1;
      if (got === want) pass_cnt = pass_cnt + 1;
      else $display("FAIL %s: got %b, expected %b", name, got, want);
   endtask

   task automatic exp4_press(input int t, input logic on_after);
      q4.push_back('{t, {on_after, 1'b1, 1'b1}});
      q4.push_back('{t + 1, {on_after, 1'b1, 1'b0}});
   endtask

   task automatic exp4_release(input int t, input logic on_now);
      q4.push_back('{t, {on_now, 1'b0, 1'b0}});
   endtask

   initial begin
      int e;
      int e0;
      logic [9:0] bounce;
      pass_cnt  = 0;
      total_cnt = 0;
      rst_n      = 1'b0;
      if4.btn_in = 1'b1;
      if1.btn_in = 1'b0;

      // Reset held with the button pressed: outputs stay at reset values.
      repeat (3) begin
         @(negedge clk);
         check("rst_hold_d4", cur4, 3'b000);
         check("rst_hold_d1", cur1, 3'b000);
      end

      // Release reset with button held: toggle on the 6th edge after release.
      tick();
      rst_n = 1'b1;
      e = cyc + 1;
      exp4_press(e + 5, 1'b1);
      ticks(12);

      // Release after hold: level drops 6 edges later, on stays.
      if4.btn_in = 1'b0;
      e = cyc + 1;
      exp4_release(e + 5, 1'b1);
      ticks(12);

      // Clean press held 20 cycles, then release.
      if4.btn_in = 1'b1;
      e = cyc + 1;
      exp4_press(e + 5, 1'b0);
      ticks(20);
      if4.btn_in = 1'b0;
      e = cyc + 1;
      exp4_release(e + 5, 1'b0);
      ticks(12);

      // Bounce: only the final run of 1s is long enough.
      bounce = 10'b1111101101;   // bit i = value on cycle i
      e0 = cyc + 1;
      for (int i = 0; i < 10; i++) begin
         if4.btn_in = bounce[i];
         tick();
      end
      exp4_press(e0 + 10, 1'b1);
      ticks(8);
      if4.btn_in = 1'b0;
      e = cyc + 1;
      exp4_release(e + 5, 1'b1);
      ticks(12);

      // Two full press/release cycles, each held 10 cycles.
      for (int k = 0; k < 2; k++) begin
         if4.btn_in = 1'b1;
         e = cyc + 1;
         exp4_press(e + 5, (k == 0) ? 1'b0 : 1'b1);
         ticks(10);
         if4.btn_in = 1'b0;
         e = cyc + 1;
         exp4_release(e + 5, (k == 0) ? 1'b0 : 1'b1);
         ticks(10);
      end
      ticks(4);

      // Reset in PRESS_WAIT with counter = 3 (just after edge E+4).
      if4.btn_in = 1'b1;
      e = cyc + 1;
      ticks(5);
      rst_n = 1'b0;
      #1;
      check("async_rst_d4", cur4, 3'b000);
      ticks(2);
      rst_n = 1'b1;
      e = cyc + 1;
      exp4_press(e + 5, 1'b1);
      ticks(12);
      if4.btn_in = 1'b0;
      e = cyc + 1;
      exp4_release(e + 5, 1'b1);
      ticks(12);

      // DEBOUNCE_CYCLES = 1: one-cycle pulse is accepted 3 edges later.
      if1.btn_in = 1'b1;
      e = cyc + 1;
      tick();
      if1.btn_in = 1'b0;
      q1.push_back('{e + 2, 3'b111});
      q1.push_back('{e + 3, 3'b100});
      ticks(8);

      // Three-cycle press on the single-cycle build toggles on back to 0.
      if1.btn_in = 1'b1;
      e = cyc + 1;
      ticks(3);
      if1.btn_in = 1'b0;
      q1.push_back('{e + 2, 3'b011});
      q1.push_back('{e + 3, 3'b010});
      q1.push_back('{e + 5, 3'b000});

      // Zero-length activity: button held low, nothing may happen.
      ticks(15);

      total_cnt = total_cnt + 1;
      if (q4.size() == 0) pass_cnt = pass_cnt + 1;
      else $display("FAIL d4_pending: %0d events never seen, expected 0", q4.size());
      total_cnt = total_cnt + 1;
      if (q1.size() == 0) pass_cnt = pass_cnt + 1;
      else $display("FAIL d1_pending: %0d events never seen, expected 0", q1.size());
      check("final_d4", cur4, 3'b100);
      check("final_d1", cur1, 3'b000);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
